// File: rtl/sev_segment_pkg.sv
// Shared constants for the seven-segment display: segment bit positions,
// active-high glyph patterns and the polarity helper used by the top level.
package sev_segment_pkg;

  typedef logic [6:0] seg_pattern_t;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Glyphs are active-high, bit n lights segment n (a..g = bits 0..6).
  localparam seg_pattern_t GLYPH_0 = 7'h3F;
  localparam seg_pattern_t GLYPH_1 = 7'h06;
  localparam seg_pattern_t GLYPH_2 = 7'h5B;
  localparam seg_pattern_t GLYPH_3 = 7'h4F;
  localparam seg_pattern_t GLYPH_4 = 7'h66;
  localparam seg_pattern_t GLYPH_5 = 7'h6D;
  localparam seg_pattern_t GLYPH_6 = 7'h7D;
  localparam seg_pattern_t GLYPH_7 = 7'h07;
  localparam seg_pattern_t GLYPH_8 = 7'h7F;
  localparam seg_pattern_t GLYPH_9 = 7'h6F;
  localparam seg_pattern_t GLYPH_A = 7'h77;
  localparam seg_pattern_t GLYPH_B = 7'h7C;
  localparam seg_pattern_t GLYPH_C = 7'h39;
  localparam seg_pattern_t GLYPH_D = 7'h5E;
  localparam seg_pattern_t GLYPH_E = 7'h79;
  localparam seg_pattern_t GLYPH_F = 7'h71;

  localparam seg_pattern_t SEG_BLANK = 7'h00;

  // Common-anode boards want every bit inverted, blank included.
  function automatic seg_pattern_t apply_polarity(input seg_pattern_t pattern,
                                                  input logic active_low);
    return active_low ? ~pattern : pattern;
  endfunction

endpackage

// File: rtl/sev_segment_decoder.sv
// Combinational BCD to active-high segment pattern decoder.
// Define SEV_SEGMENT_HEX_DECODE_EN to show codes 10-15 as A b C d E F.
module sev_segment_decoder
  import sev_segment_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_BLANK;
    case (bcd)
      4'd0:  pattern = GLYPH_0;
      4'd1:  pattern = GLYPH_1;
      4'd2:  pattern = GLYPH_2;
      4'd3:  pattern = GLYPH_3;
      4'd4:  pattern = GLYPH_4;
      4'd5:  pattern = GLYPH_5;
      4'd6:  pattern = GLYPH_6;
      4'd7:  pattern = GLYPH_7;
      4'd8:  pattern = GLYPH_8;
      4'd9:  pattern = GLYPH_9;
`ifdef SEV_SEGMENT_HEX_DECODE_EN
      4'd10: pattern = GLYPH_A;
      4'd11: pattern = GLYPH_B;
      4'd12: pattern = GLYPH_C;
      4'd13: pattern = GLYPH_D;
      4'd14: pattern = GLYPH_E;
      4'd15: pattern = GLYPH_F;
`else
      // Non-decimal codes stay dark so a stray value never looks like a digit.
      default: pattern = SEG_BLANK;
`endif
    endcase
  end

endmodule

// File: rtl/sev_segment_display.sv
// Registered single-digit seven-segment driver with selectable polarity.
// Hex glyphs for codes 10-15 are enabled by SEV_SEGMENT_HEX_DECODE_EN.
module sev_segment_display
  import sev_segment_pkg::*;
#(
  parameter logic ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  logic [6:0] pattern;
  logic [6:0] drive;

  sev_segment_decoder u_decoder (
    .bcd     (bcd),
    .pattern (pattern)
  );

  assign drive = apply_polarity(pattern, ACTIVE_LOW);

  // seg comes straight from this flop so the pins never glitch on bcd changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= apply_polarity(SEG_BLANK, ACTIVE_LOW);
    end else begin
      seg <= drive;
    end
  end

endmodule

// File: tb/tb_sev_segment_display.sv
// Scoreboard bench for sev_segment_display, exercising both polarities side by side.
module tb_sev_segment_display;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] bcd = 4'd0;
  logic [6:0] seg_cc;
  logic [6:0] seg_ca;

  int compared   = 0;
  int mismatched = 0;

  logic [6:0] exp_q[$];
  logic [6:0] held;
  logic       have_held = 1'b0;
  logic [3:0] sweep [6] = '{4'd5, 4'd1, 4'd0, 4'd9, 4'd8, 4'd3};

  always #5 clk = ~clk;

  sev_segment_display #(.ACTIVE_LOW(1'b0)) u_dut_cc (
    .clk (clk),
    .rst (rst),
    .bcd (bcd),
    .seg (seg_cc)
  );

  sev_segment_display #(.ACTIVE_LOW(1'b1)) u_dut_ca (
    .clk (clk),
    .rst (rst),
    .bcd (bcd),
    .seg (seg_ca)
  );

  function automatic logic [6:0] model_glyph(input logic [3:0] d);
    logic [6:0] g;
    g = 7'h00;
    case (d)
      4'd0: g = 7'h3F;
      4'd1: g = 7'h06;
      4'd2: g = 7'h5B;
      4'd3: g = 7'h4F;
      4'd4: g = 7'h66;
      4'd5: g = 7'h6D;
      4'd6: g = 7'h7D;
      4'd7: g = 7'h07;
      4'd8: g = 7'h7F;
      4'd9: g = 7'h6F;
`ifdef SEV_SEGMENT_HEX_DECODE_EN
      4'd10: g = 7'h77;
      4'd11: g = 7'h7C;
      4'd12: g = 7'h39;
      4'd13: g = 7'h5E;
      4'd14: g = 7'h79;
      4'd15: g = 7'h71;
`endif
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  task automatic check_output(input string tag, input logic [6:0] actual,
                              input logic [6:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: seg=%02h expected=%02h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drive one cycle of stimulus, confirm seg holds until the edge, then score it.
  task automatic apply_stimulus(input logic r, input logic [3:0] d, input string tag);
    logic [6:0] e;
    @(negedge clk);
    rst = r;
    bcd = d;
    exp_q.push_back(r ? 7'h00 : model_glyph(d));
    #1;
    if (have_held) begin
      check_output({tag, "_hold"}, seg_cc, held);
    end
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: scoreboard empty, seg=%02h", tag, seg_cc);
    end else begin
      e = exp_q.pop_front();
      check_output(tag, seg_cc, e);
      check_output({tag, "_al"}, seg_ca, ~e);
      held      = e;
      have_held = 1'b1;
    end
  endtask

  initial begin
    repeat (2) apply_stimulus(1'b1, 4'd5, "reset");
    apply_stimulus(1'b0, 4'd5, "release");

    foreach (sweep[i]) begin
      repeat (5) apply_stimulus(1'b0, sweep[i], "sweep");
    end

    for (int c = 10; c < 16; c++) begin
      repeat (2) apply_stimulus(1'b0, 4'(c), "code");
    end
    apply_stimulus(1'b0, 4'd7, "after_code");

    apply_stimulus(1'b0, 4'd5, "pol_5");
    apply_stimulus(1'b0, 4'd8, "pol_8");
    apply_stimulus(1'b1, 4'd8, "pol_rst");

    repeat (3) apply_stimulus(1'b0, 4'd9, "mid_pre");
    apply_stimulus(1'b1, 4'd9, "mid_rst");
    repeat (3) apply_stimulus(1'b0, 4'd9, "mid_post");

    for (int k = 0; k < 40; k++) begin
      apply_stimulus(1'b0, 4'($urandom_range(0, 15)), "random");
    end

    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
